// File: rtl/dm9000a_delay_ch.sv
// dm9000a_delay_ch
//   One microsecond delay channel for the DM9000A sequencers. It holds a
//   per-channel prescaler that divides the clock down to microseconds, a
//   microsecond counter, and the delay value and mode latched at start.
//   A channel runs one-shot (stops in DONE) or periodic (reloads and
//   keeps running).
//
// Ports
//   iClk        in   clock, rising edge
//   iRst        in   asynchronous active-high reset
//   iStart      in   start/retrigger; latches iDelayTime and iPeriodic
//   iAbort      in   abort to IDLE; takes priority over iStart
//   iPeriodic   in   0 one-shot, 1 periodic (latched on start)
//   iDelayTime  in   delay in microseconds (latched on start)
//   oBusy       out  channel counting
//   oRunEnd     out  one-shot expired; held until the next start or abort
//   oDonePulse  out  one-cycle pulse on every expiry
module dm9000a_delay_ch #(
    parameter int unsigned DW           = 11,
    parameter int unsigned TICKS_PER_US = 25
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStart,
    input  logic          iAbort,
    input  logic          iPeriodic,
    input  logic [DW-1:0] iDelayTime,
    output logic          oBusy,
    output logic          oRunEnd,
    output logic          oDonePulse
);

    localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_US - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_us;
    logic [DW-1:0] r_delay;
    logic          r_periodic;
    logic          r_busy;
    logic          r_run_end;
    logic          r_pulse;

    logic w_wrap;
    logic w_zero_delay;
    logic w_expire;

    assign w_wrap       = (r_presc == PRESC_LAST);
    assign w_zero_delay = (r_delay == '0);
    // A zero delay expires on the first edge after start, independent of the prescaler.
    assign w_expire     = w_zero_delay || (w_wrap && (r_us == r_delay - DW'(1)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_us       <= '0;
            r_delay    <= '0;
            r_periodic <= 1'b0;
            r_busy     <= 1'b0;
            r_run_end  <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (iAbort) begin
                r_state   <= IDLE;
                r_presc   <= '0;
                r_us      <= '0;
                r_busy    <= 1'b0;
                r_run_end <= 1'b0;
            end else if (iStart) begin
                // Retrigger discards any elapsed time.
                r_state    <= RUN;
                r_delay    <= iDelayTime;
                r_periodic <= iPeriodic;
                r_presc    <= '0;
                r_us       <= '0;
                r_busy     <= 1'b1;
                r_run_end  <= 1'b0;
            end else if (r_state == RUN) begin
                if (w_expire) begin
                    r_pulse <= 1'b1;
                    r_presc <= '0;
                    r_us    <= '0;
                    // Periodic with zero delay would pulse every cycle; treat it as one-shot.
                    if (!(r_periodic && !w_zero_delay)) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_run_end <= 1'b1;
                    end
                end else if (w_wrap) begin
                    r_presc <= '0;
                    r_us    <= r_us + DW'(1);
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    assign oBusy      = r_busy;
    assign oRunEnd    = r_run_end;
    assign oDonePulse = r_pulse;

endmodule

// File: rtl/dm9000a_delay_timer.sv
// dm9000a_delay_timer
//   Multi-channel microsecond delay timer used by the DM9000A power-up,
//   reset-pulse and PHY-settle sequencers. Each channel is an independent
//   dm9000a_delay_ch; nothing is shared between channels.
//
// Ports
//   iDm9000aClk  in   25 MHz clock, rising edge
//   iRst         in   asynchronous active-high reset
//   iStart       in   per-channel start/retrigger
//   iAbort       in   per-channel abort (wins over start)
//   iPeriodic    in   per-channel mode, latched on start
//   iDelayTime   in   per-channel delay in us, channel c at [c*DW +: DW]
//   oBusy        out  per-channel counting
//   oRunEnd      out  per-channel one-shot expired (held)
//   oDonePulse   out  per-channel one-cycle expiry pulse
module dm9000a_delay_timer #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned DW           = 11,
    parameter int unsigned TICKS_PER_US = 25
) (
    input  logic               iDm9000aClk,
    input  logic               iRst,
    input  logic [N_CH-1:0]    iStart,
    input  logic [N_CH-1:0]    iAbort,
    input  logic [N_CH-1:0]    iPeriodic,
    input  logic [N_CH*DW-1:0] iDelayTime,
    output logic [N_CH-1:0]    oBusy,
    output logic [N_CH-1:0]    oRunEnd,
    output logic [N_CH-1:0]    oDonePulse
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        dm9000a_delay_ch #(
            .DW           (DW),
            .TICKS_PER_US (TICKS_PER_US)
        ) u_ch (
            .iClk       (iDm9000aClk),
            .iRst       (iRst),
            .iStart     (iStart[g]),
            .iAbort     (iAbort[g]),
            .iPeriodic  (iPeriodic[g]),
            .iDelayTime (iDelayTime[g*DW +: DW]),
            .oBusy      (oBusy[g]),
            .oRunEnd    (oRunEnd[g]),
            .oDonePulse (oDonePulse[g])
        );
    end

endmodule

// File: tb/tb_dm9000a_delay_timer.sv
// tb_dm9000a_delay_timer
//   Drives two timers (25 ticks/us and 1 tick/us) with the same inputs.
//   A deadline-based reference model predicts every cycle's outputs and
//   queues them; a negedge monitor pops and compares.
module tb_dm9000a_delay_timer;

    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 11;
    localparam int unsigned T0  = 25;
    localparam int unsigned T1  = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH-1:0]     start = '0;
    logic [NCH-1:0]     abort = '0;
    logic [NCH-1:0]     periodic = '0;
    logic [NCH*DW-1:0]  dly = '0;

    logic [NCH-1:0] busy0, runend0, pulse0;
    logic [NCH-1:0] busy1, runend1, pulse1;

    always #5 clk = ~clk;

    dm9000a_delay_timer #(.N_CH(NCH), .DW(DW), .TICKS_PER_US(T0)) u_dut0 (
        .iDm9000aClk (clk),
        .iRst        (rst),
        .iStart      (start),
        .iAbort      (abort),
        .iPeriodic   (periodic),
        .iDelayTime  (dly),
        .oBusy       (busy0),
        .oRunEnd     (runend0),
        .oDonePulse  (pulse0)
    );

    dm9000a_delay_timer #(.N_CH(NCH), .DW(DW), .TICKS_PER_US(T1)) u_dut1 (
        .iDm9000aClk (clk),
        .iRst        (rst),
        .iStart      (start),
        .iAbort      (abort),
        .iPeriodic   (periodic),
        .iDelayTime  (dly),
        .oBusy       (busy1),
        .oRunEnd     (runend1),
        .oDonePulse  (pulse1)
    );

    typedef struct packed {
        logic [1:0] b0, r0, p0, b1, r1, p1;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_exp;
    exp_t   mon_got;
    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;

    // Reference model: each running channel has an absolute expiry cycle.
    bit     m_run  [2][2];
    bit     m_done [2][2];
    bit     m_per  [2][2];
    bit     m_pulse[2][2];
    longint m_dl   [2][2];
    longint m_len  [2][2];

    function automatic longint tpu(int i);
        return (i == 0) ? longint'(T0) : longint'(T1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_run[i][c]   = 1'b0;
                m_done[i][c]  = 1'b0;
                m_per[i][c]   = 1'b0;
                m_pulse[i][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        exp_t   e;
        longint d;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_pulse[i][c] = 1'b0;
                if (rst) begin
                    m_run[i][c]  = 1'b0;
                    m_done[i][c] = 1'b0;
                end else if (abort[c]) begin
                    m_run[i][c]  = 1'b0;
                    m_done[i][c] = 1'b0;
                end else if (start[c]) begin
                    d = longint'(dly[c*DW +: DW]);
                    m_run[i][c]  = 1'b1;
                    m_done[i][c] = 1'b0;
                    if (d == 0) begin
                        m_dl[i][c]  = cyc + 1;
                        m_per[i][c] = 1'b0;
                    end else begin
                        m_len[i][c] = d * tpu(i);
                        m_dl[i][c]  = cyc + m_len[i][c];
                        m_per[i][c] = periodic[c];
                    end
                end else if (m_run[i][c] && cyc == m_dl[i][c]) begin
                    m_pulse[i][c] = 1'b1;
                    if (m_per[i][c]) begin
                        m_dl[i][c] = m_dl[i][c] + m_len[i][c];
                    end else begin
                        m_run[i][c]  = 1'b0;
                        m_done[i][c] = 1'b1;
                    end
                end
            end
        end
        e.b0 = {m_run[0][1],   m_run[0][0]};
        e.r0 = {m_done[0][1],  m_done[0][0]};
        e.p0 = {m_pulse[0][1], m_pulse[0][0]};
        e.b1 = {m_run[1][1],   m_run[1][0]};
        e.r1 = {m_done[1][1],  m_done[1][0]};
        e.p1 = {m_pulse[1][1], m_pulse[1][0]};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_exp = q.pop_front();
            mon_got = {busy0, runend0, pulse0, busy1, runend1, pulse1};
            vectors++;
            if (mon_got !== mon_exp) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got b0=%b r0=%b p0=%b b1=%b r1=%b p1=%b, want b0=%b r0=%b p0=%b b1=%b r1=%b p1=%b",
                         cyc, mon_got.b0, mon_got.r0, mon_got.p0, mon_got.b1, mon_got.r1,
                         mon_got.p1, mon_exp.b0, mon_exp.r0, mon_exp.p0, mon_exp.b1,
                         mon_exp.r1, mon_exp.p1);
            end
        end
    end

    // One clock: model the edge, then present fresh one-cycle inputs.
    // Delay/mode are scrambled every cycle to show they are only used at start.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        start    = '0;
        abort    = '0;
        dly      = (NCH*DW)'($urandom);
        periodic = NCH'($urandom);
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic go(int c, int d, bit per);
        start[c]           = 1'b1;
        dly[c*DW +: DW]    = DW'(d);
        periodic[c]        = per;
        tick();
    endtask

    // Called right after tick(): asserts reset mid-cycle and checks the async clear.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        q.delete();
        model_clear();
        #1;
        vectors++;
        if ({busy0, runend0, pulse0, busy1, runend1, pulse1} !== 12'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b, want 0",
                     {busy0, runend0, pulse0, busy1, runend1, pulse1});
        end
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        run(3);
        rst = 1'b0;
        run(5);

        // Reset while channel 0 is counting.
        go(0, 10, 1'b0);
        run(99);
        async_reset();
        run(300);

        // One-shot, 4 us.
        go(0, 4, 1'b0);
        run(130);

        // Periodic 2 us on ch1, aborted between the 2nd and 3rd pulse.
        go(1, 2, 1'b1);
        run(119);
        abort[1] = 1'b1;
        tick();
        run(60);

        // Retrigger discards elapsed time.
        go(0, 3, 1'b0);
        run(59);
        go(0, 1, 1'b0);
        run(40);
        // Start and abort together while running: abort wins.
        go(0, 5, 1'b0);
        run(10);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        dly[DW-1:0] = DW'(2);
        tick();
        run(150);

        // Zero delay, one-shot and periodic.
        go(0, 0, 1'b0);
        run(3);
        go(0, 0, 1'b1);
        run(3);
        go(1, 0, 1'b1);
        run(3);

        // Maximum delay; expires on the 1-tick/us instance.
        go(0, 2047, 1'b0);
        run(2060);
        abort = 2'b11;
        tick();
        run(3);

        // Both channels together, then abort ch0 only.
        start = 2'b11;
        dly   = {DW'(3), DW'(1)};
        periodic = 2'b00;
        tick();
        run(30);
        abort[0] = 1'b1;
        tick();
        run(60);

        // Random traffic.
        repeat (3000) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 149) == 0) begin
                    start[c]        = 1'b1;
                    dly[c*DW +: DW] = DW'($urandom_range(0, 8));
                end
                if ($urandom_range(0, 399) == 0) abort[c] = 1'b1;
            end
            tick();
        end

        tick();
        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
